// File: rtl/karatsuba_pkg.sv
// Shared types and elaboration helpers for the iterative Karatsuba multiplier.
package karatsuba_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LL   = 3'd1,
    HH   = 3'd2,
    MID  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic int karatsuba_half(input int w);
    return w / 2;
  endfunction

  // Operands must split into two equal halves of at least 4 bits.
  function automatic bit karatsuba_width_ok(input int w);
    return (w % 2 == 0) && (w >= 8);
  endfunction

endpackage

// File: rtl/karatsuba_dp.sv
// Per-step datapath: half-width operand muxes, pre-adders, the lone H x H multiplier,
// cross-term corrections and the Z/T accumulator updates, selected by FSM state.
module karatsuba_dp
  import karatsuba_pkg::*;
#(
  parameter int W = 32
) (
  input  state_t         state,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2*W-1:0] z,
  input  logic [W:0]     t,
  output logic [2*W-1:0] z_next,
  output logic [W:0]     t_next
);

  localparam int H = karatsuba_half(W);

  logic [H:0]   sa;
  logic [H:0]   sb;
  logic [H-1:0] x;
  logic [H-1:0] y;
  logic [W-1:0] prod;
  logic [W+1:0] p;
  logic [W+1:0] m;

  assign sa = {1'b0, a[W-1:H]} + {1'b0, a[H-1:0]};
  assign sb = {1'b0, b[W-1:H]} + {1'b0, b[H-1:0]};

  always_comb begin
    x = a[H-1:0];
    y = b[H-1:0];
    case (state)
      HH: begin
        x = a[W-1:H];
        y = b[W-1:H];
      end
      MID: begin
        x = sa[H-1:0];
        y = sb[H-1:0];
      end
      default: ;
    endcase
  end

  // Upper halves are zero, so this is the single H x H product.
  assign prod = {{H{1'b0}}, x} * {{H{1'b0}}, y};

  // The pre-adder carries contribute the terms the H-bit product cannot see.
  assign p = {2'b00, prod}
           + {2'b00, sa[H-1:0] & {H{sb[H]}}, {H{1'b0}}}
           + {2'b00, sb[H-1:0] & {H{sa[H]}}, {H{1'b0}}}
           + {1'b0, sa[H] & sb[H], {W{1'b0}}};
  assign m = p - {1'b0, t};

  always_comb begin
    z_next = z;
    t_next = t;
    case (state)
      LL: begin
        z_next = z + {{W{1'b0}}, prod};
        t_next = {1'b0, prod};
      end
      HH: begin
        z_next = z + {prod, {W{1'b0}}};
        t_next = t + {1'b0, prod};
      end
      MID: z_next = z + ({{(W-2){1'b0}}, m} << H);
      default: ;
    endcase
  end

endmodule

// File: rtl/iterative_karatsuba_nbit.sv
// W-bit iterative Karatsuba multiplier with valid/ready on both sides; four edges accept-to-result.
// KARATSUBA_SIGNED_EN adds the tc port and two's-complement operand handling.
module iterative_karatsuba_nbit
  import karatsuba_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
`ifdef KARATSUBA_SIGNED_EN
  input  logic           tc,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] C
);

  localparam bit WIDTH_OK = karatsuba_width_ok(W);

  generate
    if (!WIDTH_OK) begin : g_bad_width
      $error("iterative_karatsuba_nbit: W must be even and >= 8");
    end
  endgenerate

  state_t         state;
  state_t         state_n;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] z_q;
  logic [W:0]     t_q;
  logic [2*W-1:0] c_q;
  logic [2*W-1:0] z_n;
  logic [W:0]     t_n;
  logic [2*W-1:0] c_d;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           accept;

  assign accept = in_valid && (state == IDLE);

`ifdef KARATSUBA_SIGNED_EN
  logic sign_q;
  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign a_in = (tc && A[W-1]) ? -A : A;
  assign b_in = (tc && B[W-1]) ? -B : B;
  assign c_d  = sign_q ? -z_n : z_n;

  always_ff @(posedge clk) begin
    if (rst)         sign_q <= 1'b0;
    else if (accept) sign_q <= tc && (A[W-1] ^ B[W-1]);
  end
`else
  assign a_in = A;
  assign b_in = B;
  assign c_d  = z_n;
`endif

  karatsuba_dp #(.W(W)) u_dp (
    .state  (state),
    .a      (a_q),
    .b      (b_q),
    .z      (z_q),
    .t      (t_q),
    .z_next (z_n),
    .t_next (t_n)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = LL;
      LL:      state_n = HH;
      HH:      state_n = MID;
      MID:     state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      z_q <= '0;
      t_q <= '0;
      c_q <= '0;
    end else if (accept) begin
      a_q <= a_in;
      b_q <= b_in;
      z_q <= '0;
      t_q <= '0;
    end else if (state == LL || state == HH || state == MID) begin
      z_q <= z_n;
      t_q <= t_n;
      if (state == MID) c_q <= c_d;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign C         = c_q;

endmodule

// File: tb/tb_iterative_karatsuba_nbit.sv
// Directed self-checking bench for iterative_karatsuba_nbit at W=32 and W=16.
module tb_iterative_karatsuba_nbit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        tc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] c;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        tc16;
  logic        out_valid16;
  logic        out_ready16;
  logic [31:0] c16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iterative_karatsuba_nbit #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
`ifdef KARATSUBA_SIGNED_EN
    .tc        (tc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (c)
  );

  iterative_karatsuba_nbit #(.W(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .A         (a16),
    .B         (b16),
`ifdef KARATSUBA_SIGNED_EN
    .tc        (tc16),
`endif
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .C         (c16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Presents one operand pair and returns just after the accept edge.
  task automatic start(input logic [31:0] av, input logic [31:0] bv, input logic tcv);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    tc       = tcv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    tc       = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ov_after"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_ir_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic tcv, input logic [63:0] exp);
    start(av, bv, tcv);
    wait_done(tag);
    chk({tag, "_c"}, c, exp);
    chk({tag, "_ir_busy"}, {63'd0, in_ready}, 64'd0);
    take(tag);
  endtask

  initial begin
    int lat16;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    tc          = 1'b0;
    in_valid16  = 1'b0;
    out_ready16 = 1'b0;
    a16         = '0;
    b16         = '0;
    tc16        = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ir", {63'd0, in_ready}, 64'd1);
    chk("reset_ov", {63'd0, out_valid}, 64'd0);
    chk("reset_c", c, 64'd0);

    run("basic", 32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E242D2080);
    run("allones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
    run("zero", 32'h00000000, 32'hDEADBEEF, 1'b0, 64'h0);
    run("one", 32'h00000001, 32'hDEADBEEF, 1'b0, 64'h00000000DEADBEEF);

    // Output held back: product and handshake flags must not move, new operands ignored.
    start(32'h00010000, 32'h00010000, 1'b0);
    wait_done("hold");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      a        = 32'h00000007;
      b        = 32'h00000009;
      @(negedge clk);
      chk("hold_c", c, 64'h0000000100000000);
      chk("hold_ov", {63'd0, out_valid}, 64'd1);
      chk("hold_ir", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    take("hold");

    // Reset arrives while in HH: the operation is abandoned.
    start(32'h00001234, 32'h00005678, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ir", {63'd0, in_ready}, 64'd1);
    chk("abort_ov", {63'd0, out_valid}, 64'd0);
    chk("abort_c", c, 64'd0);
    run("after_abort", 32'd3, 32'd5, 1'b0, 64'd15);

    // Narrow instance.
    @(posedge clk);
    #1;
    in_valid16 = 1'b1;
    a16        = 16'hFFFF;
    b16        = 16'hFFFF;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    lat16 = 1;
    @(negedge clk);
    while (!out_valid16 && lat16 < 20) begin
      @(negedge clk);
      lat16++;
    end
    chk("w16_latency", 64'(lat16), 64'd4);
    chk("w16_c", {32'd0, c16}, 64'h00000000FFFE0001);
    out_ready16 = 1'b1;
    @(posedge clk);
    #1 out_ready16 = 1'b0;
    @(negedge clk);
    chk("w16_ir_after", {63'd0, in_ready16}, 64'd1);

`ifdef KARATSUBA_SIGNED_EN
    run("s_neg3x7", 32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFEB);
    run("s_minsq", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
    run("s_tc0", 32'hFFFFFFFD, 32'h00000007, 1'b0, 64'h00000006FFFFFFEB);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iterative_karatsuba_nbit.md
# iterative_karatsuba_nbit

Parametrised iterative Karatsuba multiplier for W-bit operands, producing a 2W-bit product. It reuses one combinational (W/2)-bit multiplier over three compute cycles: low×low, high×high, then the cross term. It generalises the fixed 32-bit iterative multiplier in three ways: any even width, a valid/ready handshake on both sides with output backpressure, and optional two's-complement operands. It sits between an operand-issuing sequencer and a result consumer in the arithmetic datapath.

## Interface
- W, 32, operand width; must be even and ≥ 8; H = W/2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present on A/B.
- in_ready  out  1  block can accept operands; high only in IDLE.
- A  in  W  multiplicand.
- B  in  W  multiplier.
- tc  in  1  treat A/B as two's complement; present only with KARATSUBA_SIGNED_EN.
- out_valid  out  1  C holds a finished product.
- out_ready  in  1  consumer takes C.
- C  out  2W  product; registered.

## Operation
- Reset is synchronous and active-high on clk. After reset: state IDLE, in_ready=1, out_valid=0, C=0, internal Z/T/operand registers 0.
- FSM states and transitions:
  - IDLE: on in_valid&&in_ready, latch A and B, clear Z, go to LL.
  - LL: Z += Al·Bl; go to HH.
  - HH: Z += Ah·Bh<<W; T = Al·Bl + Ah·Bh (W+1 bits); go to MID.
  - MID: Z += M<<H; go to DONE.
  - DONE: out_valid=1; go to IDLE on out_ready; otherwise hold.
- Cross term: Sa = Ah+Al and Sb = Bh+Bl, each H bits plus carries ca and cb.
  - P = Sa[H-1:0]·Sb[H-1:0] + (cb ? Sa[H-1:0]<<H : 0) + (ca ? Sb[H-1:0]<<H : 0) + ((ca&cb)<<W), in W+2 bits.
  - M = P − T, in W+2 bits; M is never negative.
- Only the single H×H multiplier instance may form products. No other multiply operator is allowed in the RTL.
- All accumulation is modulo 2^(2W). The final Z equals A·B exactly.
- in_valid is ignored outside IDLE. A and B may change freely after acceptance.
- rst asserted in any state aborts the operation and restores the reset values on the next edge. No partial result is emitted.
- out_valid and in_ready are never both high.

## Timing
- Accept edge t0 (in_valid&&in_ready sampled high): state is LL in cycle t0+1, HH in t0+2, MID in t0+3.
- out_valid rises in cycle t0+4, i.e. after 4 edges. C is valid in that same cycle.
- C and out_valid stay stable while out_ready is low.
- Handshake edge (out_valid&&out_ready): out_valid falls and in_ready rises on the next cycle.
- Maximum throughput is one product per 5 cycles; back-to-back accept and emit in the same cycle is not supported.
- in_ready, out_valid and C are decoded or registered from state only. No combinational path from in_valid or out_ready to any output.

## Configuration
- KARATSUBA_SIGNED_EN defined:
  - tc port exists and is latched at accept.
  - If tc=1, |A| and |B| are latched and sign = A[W-1]^B[W-1] is stored.
  - In DONE, C = sign ? −Z : Z (2W-bit two's complement). Latency is unchanged.
  - The most negative operand (0x8000…) is handled, because its magnitude fits in W unsigned bits.
- KARATSUBA_SIGNED_EN undefined: no tc port; operands are unsigned; no sign or negation logic.

## Structure
- Package karatsuba_pkg holds:
  - the state enum (IDLE, LL, HH, MID, DONE);
  - a function karatsuba_half(W) returning W/2;
  - a width-check constant that raises an elaboration error for odd W or W < 8.
- One sub-module, karatsuba_dp: the step datapath. It contains the operand muxes, both H-bit pre-adders with carries, the single H×H multiplier, the correction adds, the T subtraction and the Z accumulator adder, all selected by state. The top level holds the FSM and the registers.

## Test plan
- W=32: A=0x12345678, B=0x9ABCDEF0 → C=0x0B00EA4E242D2080, with out_valid exactly 4 edges after accept.
- W=32: A=B=0xFFFFFFFF (ca=cb=1) → C=0xFFFFFFFE00000001. W=16: A=B=0xFFFF → C=0xFFFE0001.
- A=0, B=0xDEADBEEF → C=0. Then A=1, B=0xDEADBEEF issued right after handshake → C=0x00000000DEADBEEF.
- Hold out_ready low 6 cycles in DONE → C, out_valid=1 and in_ready=0 all stable; in_valid pulses during hold are ignored.
- Assert rst for 1 cycle while in HH → next cycle in_ready=1, out_valid=0, C=0; a following 3×5 operation gives C=15.
- KARATSUBA_SIGNED_EN, tc=1:
  - A=0xFFFFFFFD (−3), B=7 → C=0xFFFFFFFFFFFFFFEB.
  - A=B=0x80000000 → C=0x4000000000000000.
  - Same A=0xFFFFFFFD, B=7 with tc=0 → C=0x00000006FFFFFFEB.
